ai_mover_m: RTL and testbench
=============================

AI_MOVER_M -- requirements
Module: ai_mover_m

Interface
REQ-001 SHALL have parameter AI_CELL, default `CELL_O, the mark the AI places.
REQ-002 SHALL have parameter OPP_CELL, default `CELL_X, the mark of the human player.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port turn, input, `FLAG_T (1), whose move it is: `TURN_AI (1) or `TURN_PLAYER (0).
REQ-006 SHALL have port board, input, `BOARD_T `STATE_T (9 cells x 2 bits), current cells, index 0..8 row-major, `CELL_BLANK = 0.
REQ-007 SHALL have port update_loc, output, `INDEX_T (4), the chosen cell index.
REQ-008 SHALL have port submit, output, `FLAG_T, move strobe; the board commits the move on its falling edge.
REQ-009 SHALL have port busy, output, 1, high in SCAN and SUBMIT.
REQ-010 SHALL have port no_move, output, 1, sticky flag: the scan found no blank cell.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, SUBMIT, WAIT, HALT.
REQ-012 IDLE: on a posedge with turn==`TURN_AI, SHALL copy board into an internal snapshot, set pass=0 and idx=0, and go to SCAN.
REQ-013 SCAN SHALL evaluate exactly one (pass, idx) candidate per cycle against the snapshot only; board changes during SCAN SHALL be ignored.
REQ-014 Pass order SHALL be: 0 WIN (cell blank and AI_CELL there completes a line), 1 BLOCK (cell blank and OPP_CELL there completes a line), 2 CENTER (idx==4 and blank), 3 CORNER (idx in {0,2,6,8} and blank), 4 ANY (blank).
REQ-015 Within a pass, idx SHALL advance 0..8; after idx 8 it SHALL wrap to 0 and pass SHALL increment.
REQ-016 Timing: with IDLE detecting turn in cycle 0, candidate (p,i) SHALL be evaluated in cycle 1+9p+i.
REQ-017 On a hit, SHALL latch update_loc=idx and enter SUBMIT; submit SHALL be 1 in cycle 2+9p+i.
REQ-018 SUBMIT SHALL last exactly one cycle, then submit=0 and the FSM enters WAIT; update_loc SHALL hold until WAIT exits.
REQ-019 WAIT SHALL return to IDLE on the first posedge with turn==`TURN_PLAYER, setting update_loc=`INDEX_NONE (4'hF); it SHALL never re-submit.
REQ-020 If pass 4 idx 8 misses, the FSM SHALL enter HALT with no_move=1 and update_loc=`INDEX_NONE, and SHALL never assert submit; HALT SHALL be left only by reset.
REQ-021 update_loc SHALL be either 0..8 or `INDEX_NONE; the index counter SHALL never exceed 8.
REQ-022 turn==`TURN_AI remaining asserted in IDLE after a move SHALL NOT be treated as new until WAIT has seen `TURN_PLAYER.

Reset
REQ-023 reset asserted SHALL immediately force state=IDLE, submit=0, update_loc=`INDEX_NONE, busy=0, no_move=0, pass=0, idx=0.
REQ-024 On reset during SUBMIT, submit SHALL fall together with update_loc becoming `INDEX_NONE, so the resulting falling edge carries an out-of-range index and commits no move.
REQ-025 After reset deasserts, the FSM SHALL act on the first posedge with turn==`TURN_AI.

Structure
REQ-026 defines.v SHALL hold `INDEX_NONE, the pass encodings (PASS_WIN..PASS_ANY), and the FSM state encodings, alongside the existing BOARD_T, STATE_T, INDEX_T, CELL_* and TURN_* definitions.
REQ-027 A combinational sub-module ai_line_eval_m (snapshot, idx, mark -> completes_line) SHALL check the 8 lines through a cell; it SHALL be instantiated twice (AI_CELL, OPP_CELL).

Verification
REQ-028 X at 0, rest blank, turn->AI at cycle 0 -> submit=1 in cycle 24 with update_loc=4; submit=0 in cycle 25.
REQ-029 O at 0,1 and X at 3,4, turn->AI -> WIN hit: update_loc=2, submit=1 in cycle 4.
REQ-030 X at 0,1 and O at 4, turn->AI -> BLOCK hit: update_loc=2, submit=1 in cycle 13.
REQ-031 All 9 cells non-blank, turn->AI -> submit stays 0; no_move=1 and update_loc=15 from cycle 46; the FSM stays in HALT until reset.
REQ-032 reset pulsed while submit=1 -> submit=0 and update_loc=15 in the same instant, busy=0, board state unchanged.
REQ-033 turn held at AI for 10 cycles after a submit -> exactly one submit pulse; a new scan starts only after turn goes PLAYER and then AI.

Source files
------------

// File: rtl/ai_mover_m_pkg.sv
// rtl/ai_mover_m_pkg.sv - shared types, encodings and board helpers for the tic-tac-toe AI mover
package ai_mover_m_pkg;

  typedef logic [1:0]  cell_t;
  typedef logic [17:0] board_t;
  typedef logic [3:0]  index_t;

  localparam cell_t  CELL_BLANK  = 2'd0;
  localparam cell_t  CELL_X      = 2'd1;
  localparam cell_t  CELL_O      = 2'd2;

  localparam logic   TURN_AI     = 1'b1;
  localparam logic   TURN_PLAYER = 1'b0;

  localparam index_t INDEX_NONE  = 4'hF;
  localparam index_t INDEX_LAST  = 4'd8;
  localparam index_t INDEX_CTR   = 4'd4;

  typedef enum logic [2:0] {
    PASS_WIN    = 3'd0,
    PASS_BLOCK  = 3'd1,
    PASS_CENTER = 3'd2,
    PASS_CORNER = 3'd3,
    PASS_ANY    = 3'd4
  } pass_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_SUBMIT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic cell_t cell_at(input board_t b, input index_t i);
    return b[{i, 1'b0} +: 2];
  endfunction

  // Each line packed as {c2, c1, c0}: three rows, three columns, two diagonals.
  function automatic logic [11:0] line_cells(input logic [2:0] line);
    case (line)
      3'd0:    return {4'd2, 4'd1, 4'd0};
      3'd1:    return {4'd5, 4'd4, 4'd3};
      3'd2:    return {4'd8, 4'd7, 4'd6};
      3'd3:    return {4'd6, 4'd3, 4'd0};
      3'd4:    return {4'd7, 4'd4, 4'd1};
      3'd5:    return {4'd8, 4'd5, 4'd2};
      3'd6:    return {4'd8, 4'd4, 4'd0};
      default: return {4'd6, 4'd4, 4'd2};
    endcase
  endfunction

endpackage

// File: rtl/ai_mover_m_line_eval.sv
// rtl/ai_mover_m_line_eval.sv - ai_line_eval_m: does placing mark at idx complete any line
module ai_line_eval_m
  import ai_mover_m_pkg::*;
(
  input  logic [17:0] snapshot,
  input  logic [3:0]  idx,
  input  logic [1:0]  mark,
  output logic        completes_line
);

  logic [11:0] cl;
  index_t      c0, c1, c2;
  logic        m0, m1, m2;

  always_comb begin
    completes_line = 1'b0;
    cl = '0;
    c0 = '0;
    c1 = '0;
    c2 = '0;
    m0 = 1'b0;
    m1 = 1'b0;
    m2 = 1'b0;
    for (int l = 0; l < 8; l++) begin
      cl = line_cells(3'(l));
      c0 = cl[3:0];
      c1 = cl[7:4];
      c2 = cl[11:8];
      m0 = (cell_at(snapshot, c0) == mark);
      m1 = (cell_at(snapshot, c1) == mark);
      m2 = (cell_at(snapshot, c2) == mark);
      // The candidate cell itself is not inspected; the caller qualifies it as blank.
      if ((c0 == idx && m1 && m2) ||
          (c1 == idx && m0 && m2) ||
          (c2 == idx && m0 && m1)) begin
        completes_line = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ai_mover_m.sv
// rtl/ai_mover_m.sv - tic-tac-toe AI move picker: snapshot board, scan win/block/center/corner/any, strobe submit
module ai_mover_m
  import ai_mover_m_pkg::*;
#(
  parameter logic [1:0] AI_CELL  = CELL_O,
  parameter logic [1:0] OPP_CELL = CELL_X
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        turn,
  input  logic [17:0] board,
  output logic [3:0]  update_loc,
  output logic        submit,
  output logic        busy,
  output logic        no_move
);

  state_e state_q, state_d;
  pass_e  pass_q,  pass_d;
  index_t idx_q,   idx_d;
  board_t snap_q,  snap_d;
  index_t loc_q,   loc_d;
  logic   submit_q, submit_d;
  logic   busy_q,   busy_d;
  logic   no_move_q, no_move_d;

  logic ai_line, opp_line, blank, corner, hit;

  ai_line_eval_m u_eval_ai (
    .snapshot       (snap_q),
    .idx            (idx_q),
    .mark           (AI_CELL),
    .completes_line (ai_line)
  );

  ai_line_eval_m u_eval_opp (
    .snapshot       (snap_q),
    .idx            (idx_q),
    .mark           (OPP_CELL),
    .completes_line (opp_line)
  );

  always_comb begin
    blank  = (cell_at(snap_q, idx_q) == CELL_BLANK);
    corner = (idx_q == 4'd0) || (idx_q == 4'd2) || (idx_q == 4'd6) || (idx_q == 4'd8);
    case (pass_q)
      PASS_WIN:    hit = blank && ai_line;
      PASS_BLOCK:  hit = blank && opp_line;
      PASS_CENTER: hit = blank && (idx_q == INDEX_CTR);
      PASS_CORNER: hit = blank && corner;
      PASS_ANY:    hit = blank;
      default:     hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    loc_d     = loc_q;
    submit_d  = 1'b0;
    busy_d    = busy_q;
    no_move_d = no_move_q;
    case (state_q)
      ST_IDLE: begin
        if (turn == TURN_AI) begin
          snap_d  = board;
          pass_d  = PASS_WIN;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          loc_d    = idx_q;
          submit_d = 1'b1;
          state_d  = ST_SUBMIT;
        end else if (pass_q == PASS_ANY && idx_q == INDEX_LAST) begin
          no_move_d = 1'b1;
          loc_d     = INDEX_NONE;
          busy_d    = 1'b0;
          state_d   = ST_HALT;
        end else if (idx_q == INDEX_LAST) begin
          idx_d  = '0;
          pass_d = pass_e'(pass_q + 3'd1);
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_SUBMIT: begin
        busy_d  = 1'b0;
        state_d = ST_WAIT;
      end
      // Only a seen player turn re-arms IDLE, so a lingering AI turn never re-triggers.
      ST_WAIT: begin
        if (turn == TURN_PLAYER) begin
          loc_d   = INDEX_NONE;
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pass_q    <= PASS_WIN;
      idx_q     <= '0;
      snap_q    <= '0;
      loc_q     <= INDEX_NONE;
      submit_q  <= 1'b0;
      busy_q    <= 1'b0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      loc_q     <= loc_d;
      submit_q  <= submit_d;
      busy_q    <= busy_d;
      no_move_q <= no_move_d;
    end
  end

  assign update_loc = loc_q;
  assign submit     = submit_q;
  assign busy       = busy_q;
  assign no_move    = no_move_q;

endmodule

// File: tb/tb_ai_mover_m.sv
// tb/tb_ai_mover_m.sv - directed self-checking bench for ai_mover_m
module tb_ai_mover_m;
  import ai_mover_m_pkg::*;

  localparam logic [1:0] B_ = CELL_BLANK;
  localparam logic [1:0] X_ = CELL_X;
  localparam logic [1:0] O_ = CELL_O;

  logic        clk = 1'b0;
  logic        reset;
  logic        turn;
  logic [17:0] board;
  logic [3:0]  update_loc;
  logic        submit;
  logic        busy;
  logic        no_move;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ai_mover_m dut (
    .clk        (clk),
    .reset      (reset),
    .turn       (turn),
    .board      (board),
    .update_loc (update_loc),
    .submit     (submit),
    .busy       (busy),
    .no_move    (no_move)
  );

  function automatic logic [17:0] mk(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Turn goes AI in cycle 0; cycle k is the interval after the k-th following posedge.
  task automatic run_move(input string tag, input logic [17:0] b, input int exp_cycle, input int exp_loc);
    int         first;
    int         pulses;
    logic [3:0] loc;
    logic       busy1;
    logic       busy_after;
    first = -1;
    pulses = 0;
    loc = '0;
    busy1 = 1'b0;
    busy_after = 1'b1;
    @(negedge clk);
    board = b;
    turn  = 1'b1;
    for (int k = 1; k <= exp_cycle + 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy1 = busy;
      if (k == exp_cycle + 1) busy_after = busy;
      if (submit) begin
        pulses++;
        if (first < 0) begin
          first = k;
          loc = update_loc;
        end
      end
    end
    check({tag, "_cycle"}, first, exp_cycle);
    check({tag, "_loc"}, loc, exp_loc);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_busy_scan"}, busy1, 1);
    check({tag, "_busy_after"}, busy_after, 0);
    @(negedge clk);
    turn = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_loc_none"}, update_loc, 15);
  endtask

  logic [17:0] full_b;
  logic [17:0] win_b;
  logic        any_sub;
  logic        nm45, nm46, busy46, seen;
  logic [3:0]  loc46;

  initial begin
    reset = 1'b1;
    turn  = 1'b0;
    board = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_submit", submit, 0);
    check("rst_loc", update_loc, 15);
    check("rst_busy", busy, 0);
    check("rst_no_move", no_move, 0);
    @(negedge clk);
    reset = 1'b0;

    run_move("center", mk(X_, B_, B_, B_, B_, B_, B_, B_, B_), 24, 4);
    win_b = mk(O_, O_, B_, X_, X_, B_, B_, B_, B_);
    run_move("win", win_b, 4, 2);
    run_move("block", mk(X_, X_, B_, B_, O_, B_, B_, B_, B_), 13, 2);
    run_move("block_again", mk(X_, X_, B_, B_, O_, B_, B_, B_, B_), 13, 2);
    run_move("corner", mk(B_, B_, B_, B_, X_, B_, B_, B_, B_), 29, 0);
    run_move("any", mk(X_, O_, X_, X_, O_, B_, O_, X_, O_), 43, 5);

    // Full board: scan runs out and parks in HALT.
    full_b = mk(X_, O_, X_, X_, O_, O_, O_, X_, X_);
    any_sub = 1'b0;
    nm45 = 1'b1;
    nm46 = 1'b0;
    busy46 = 1'b1;
    loc46 = '0;
    @(negedge clk);
    board = full_b;
    turn  = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(posedge clk);
      #1;
      if (submit) any_sub = 1'b1;
      if (k == 45) nm45 = no_move;
      if (k == 46) begin
        nm46 = no_move;
        loc46 = update_loc;
        busy46 = busy;
      end
    end
    check("halt_no_submit", any_sub, 0);
    check("halt_nm45", nm45, 0);
    check("halt_nm46", nm46, 1);
    check("halt_loc46", loc46, 15);
    check("halt_busy46", busy46, 0);
    @(negedge clk);
    turn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    board = mk(B_, B_, B_, B_, B_, B_, B_, B_, B_);
    turn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (submit) any_sub = 1'b1;
    end
    check("halt_sticky_nm", no_move, 1);
    check("halt_sticky_sub", any_sub, 0);
    check("halt_sticky_busy", busy, 0);
    @(negedge clk);
    turn  = 1'b0;
    reset = 1'b1;
    #1;
    check("halt_rst_nm", no_move, 0);
    check("halt_rst_loc", update_loc, 15);
    @(negedge clk);
    reset = 1'b0;

    // Reset landing while submit is high.
    seen = 1'b0;
    @(negedge clk);
    board = win_b;
    turn  = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (submit) seen = 1'b1;
    end
    check("rst_sub_seen", seen, 1);
    reset = 1'b1;
    #1;
    check("rst_sub_submit", submit, 0);
    check("rst_sub_loc", update_loc, 15);
    check("rst_sub_busy", busy, 0);
    check("rst_sub_board", board, win_b);
    turn = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_move("after_rst", win_b, 4, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
